// File: rtl/lane_spawn_if.sv
// Handshake bundle between the spawn scheduler and its environment.
// The master side drives frame timing, random lanes and the ack; the slave
// side (the scheduler) drives the spawn request and status.
interface lane_spawn_if;
  logic       frameTick;
  logic       enable;
  logic [2:0] obstacleRand;
  logic [2:0] bananaRand;
  logic       spawnAck;
  logic       spawnReq;
  logic [2:0] spawnLane;
  logic       spawnType;
  logic       busy;
  logic [7:0] dropCount;

  modport master (
    output frameTick, enable, obstacleRand, bananaRand, spawnAck,
    input  spawnReq, spawnLane, spawnType, busy, dropCount
  );

  modport slave (
    input  frameTick, enable, obstacleRand, bananaRand, spawnAck,
    output spawnReq, spawnLane, spawnType, busy, dropCount
  );
endinterface

// File: rtl/lane_spawn_scheduler.sv
// lane_spawn_scheduler: turns free-running 3-bit random lane values into
// obstacle/banana spawn requests. Every SPAWN_PERIOD frame ticks a spawn
// event captures both lanes, forces them distinct, and issues them as two
// req/ack transactions separated by a one-cycle return-to-zero gap.
// Optional macro LANE_REPEAT_AVOID_EN: avoid repeating the previous obstacle
// lane by bumping it to the next lane.
module lane_spawn_scheduler #(
  parameter int NUM_LANES    = 5,
  parameter int SPAWN_PERIOD = 60,
  parameter int CNT_W        = 8
) (
  input  logic         clk,
  input  logic         reset,
  lane_spawn_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, OBS_REQ, GAP, BAN_REQ} state_t;

  state_t           state;
  logic [CNT_W-1:0] period_cnt;
  logic             spawn_evt;
  logic             spawn_req;
  logic [2:0]       spawn_lane;
  logic             spawn_type;
  logic [7:0]       drop_cnt;
  logic [2:0]       cap_obs;
  logic [2:0]       cap_ban;
  logic [2:0]       ban_lane;

  // Fold an out-of-range random value back into the legal lane range.
  function automatic logic [2:0] map_lane(input logic [2:0] v);
    if (v < 3'(NUM_LANES)) return v;
    else                   return v - 3'(NUM_LANES);
  endfunction

  // Neighbouring lane with wrap-around.
  function automatic logic [2:0] next_lane(input logic [2:0] v);
    if (v == 3'(NUM_LANES - 1)) return 3'd0;
    else                        return v + 3'd1;
  endfunction

  assign spawn_evt     = bus.frameTick && bus.enable &&
                         (period_cnt == CNT_W'(SPAWN_PERIOD - 1));
  assign bus.busy      = (state != IDLE);
  assign bus.spawnReq  = spawn_req;
  assign bus.spawnLane = spawn_lane;
  assign bus.spawnType = spawn_type;
  assign bus.dropCount = drop_cnt;

  // Frame-tick period counter; frozen while the game is disabled.
  always_ff @(posedge clk) begin
    if (reset)
      period_cnt <= '0;
    else if (bus.frameTick && bus.enable)
      period_cnt <= spawn_evt ? '0 : period_cnt + CNT_W'(1);
  end

`ifdef LANE_REPEAT_AVOID_EN
  logic [2:0] last_obs;
  logic       last_vld;

  // Remember the obstacle lane once the drawer has accepted it.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_obs <= '0;
      last_vld <= 1'b0;
    end else if (state == OBS_REQ && bus.spawnAck) begin
      last_obs <= spawn_lane;
      last_vld <= 1'b1;
    end
  end

  // Obstacle lane, bumped away from the previously issued one.
  always_comb begin
    cap_obs = map_lane(bus.obstacleRand);
    if (last_vld && cap_obs == last_obs)
      cap_obs = next_lane(last_obs);
  end
`else
  // Obstacle lane straight from the generator.
  always_comb cap_obs = map_lane(bus.obstacleRand);
`endif

  // Banana lane, pushed off the obstacle lane on collision.
  always_comb begin
    cap_ban = map_lane(bus.bananaRand);
    if (cap_ban == cap_obs)
      cap_ban = next_lane(cap_obs);
  end

  // Banana lane is held until BAN_REQ; pure data, so no reset needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && spawn_evt)
      ban_lane <= cap_ban;
  end

  // Handshake FSM with registered request outputs and drop counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      spawn_req  <= 1'b0;
      spawn_lane <= '0;
      spawn_type <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      if (spawn_evt && state != IDLE && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
      case (state)
        IDLE: begin
          if (spawn_evt) begin
            state      <= OBS_REQ;
            spawn_req  <= 1'b1;
            spawn_lane <= cap_obs;
            spawn_type <= 1'b0;
          end
        end
        OBS_REQ: begin
          if (bus.spawnAck) begin
            state     <= GAP;
            spawn_req <= 1'b0;
          end
        end
        GAP: begin
          state      <= BAN_REQ;
          spawn_req  <= 1'b1;
          spawn_lane <= ban_lane;
          spawn_type <= 1'b1;
        end
        BAN_REQ: begin
          if (bus.spawnAck) begin
            state     <= IDLE;
            spawn_req <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          spawn_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lane_spawn_scheduler.sv
// Bench for lane_spawn_scheduler: fixed lane-mapping vectors, hand-written
// multi-cycle sequences, and a randomized run against a transaction-level
// model that tracks the outstanding request list.
module tb_lane_spawn_scheduler;

  localparam int NL  = 5;
  localparam int PER = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  lane_spawn_if bus();

  lane_spawn_scheduler #(
    .NUM_LANES(NL),
    .SPAWN_PERIOD(PER),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: list of outstanding requests plus visible request state.
  typedef struct {
    int lane;
    int typ;
  } req_t;

  req_t m_q[$];
  int   m_cnt   = 0;
  int   m_drops = 0;
  bit   m_req   = 1'b0;
  bit   m_gap   = 1'b0;
  int   m_lane  = 0;
  int   m_type  = 0;
`ifdef LANE_REPEAT_AVOID_EN
  int   m_last     = 0;
  bit   m_last_vld = 1'b0;
`endif

  typedef struct {
    int obs_rand;
    int ban_rand;
    int obs_lane;
    int ban_lane;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int mdl_map(input int v);
    return (v < NL) ? v : v - NL;
  endfunction

  task automatic model_edge();
    bit evt;
    bit was_busy;
    int o;
    int b;
    req_t r;
    if (rst) begin
      m_q.delete();
      m_cnt = 0; m_drops = 0; m_req = 0; m_gap = 0; m_lane = 0; m_type = 0;
`ifdef LANE_REPEAT_AVOID_EN
      m_last = 0; m_last_vld = 0;
`endif
      return;
    end
    was_busy = (m_q.size() != 0);
    evt = bus.frameTick && bus.enable && (m_cnt == PER - 1);
    if (bus.frameTick && bus.enable) m_cnt = (m_cnt + 1) % PER;
    if (m_req && bus.spawnAck) begin
`ifdef LANE_REPEAT_AVOID_EN
      if (m_q[0].typ == 0) begin
        m_last = m_q[0].lane;
        m_last_vld = 1;
      end
`endif
      void'(m_q.pop_front());
      m_req = 0;
      m_gap = (m_q.size() != 0);
    end else if (m_gap) begin
      m_gap  = 0;
      m_req  = 1;
      m_lane = m_q[0].lane;
      m_type = m_q[0].typ;
    end
    if (evt) begin
      if (was_busy) begin
        if (m_drops < 255) m_drops++;
      end else begin
        o = mdl_map(int'(bus.obstacleRand));
`ifdef LANE_REPEAT_AVOID_EN
        if (m_last_vld && o == m_last) o = (m_last + 1) % NL;
`endif
        b = mdl_map(int'(bus.bananaRand));
        if (b == o) b = (o + 1) % NL;
        r.lane = o; r.typ = 0; m_q.push_back(r);
        r.lane = b; r.typ = 1; m_q.push_back(r);
        m_req = 1; m_lane = o; m_type = 0;
      end
    end
  endtask

  // One clock: model follows the edge, DUT outputs compared 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("mdl.spawnReq", int'(bus.spawnReq), int'(m_req));
    check("mdl.busy", int'(bus.busy), int'(m_q.size() != 0));
    check("mdl.dropCount", int'(bus.dropCount), m_drops);
    if (m_req) begin
      check("mdl.spawnLane", int'(bus.spawnLane), m_lane);
      check("mdl.spawnType", int'(bus.spawnType), m_type);
      check("mdl.lane_legal", int'(bus.spawnLane < 3'(NL)), 1);
    end
  endtask

  task automatic do_reset();
    bus.frameTick = 0; bus.spawnAck = 0;
    rst = 1;
    cycle();
    rst = 0;
    check("rst.spawnReq", int'(bus.spawnReq), 0);
    check("rst.busy", int'(bus.busy), 0);
    check("rst.dropCount", int'(bus.dropCount), 0);
  endtask

  // Fire one event from a zero counter and walk the full two-request handshake.
  task automatic run_event(input int orand, input int brand, input int eo, input int eb, input string tag);
    bus.obstacleRand = 3'(orand);
    bus.bananaRand   = 3'(brand);
    bus.enable = 1; bus.spawnAck = 0; bus.frameTick = 1;
    repeat (PER) cycle();
    bus.frameTick = 0;
    check({tag, ".obs_req"}, int'(bus.spawnReq), 1);
    check({tag, ".obs_lane"}, int'(bus.spawnLane), eo);
    check({tag, ".obs_type"}, int'(bus.spawnType), 0);
    repeat (3) cycle();
    check({tag, ".obs_hold"}, int'(bus.spawnReq), 1);
    check({tag, ".obs_lane_hold"}, int'(bus.spawnLane), eo);
    bus.spawnAck = 1; cycle();
    check({tag, ".gap_req"}, int'(bus.spawnReq), 0);
    check({tag, ".gap_busy"}, int'(bus.busy), 1);
    bus.spawnAck = 0; cycle();
    check({tag, ".ban_req"}, int'(bus.spawnReq), 1);
    check({tag, ".ban_lane"}, int'(bus.spawnLane), eb);
    check({tag, ".ban_type"}, int'(bus.spawnType), 1);
    bus.spawnAck = 1; cycle();
    check({tag, ".done_req"}, int'(bus.spawnReq), 0);
    check({tag, ".done_busy"}, int'(bus.busy), 0);
    bus.spawnAck = 0;
  endtask

  initial begin
    vecs[0] = '{obs_rand: 2, ban_rand: 4, obs_lane: 2, ban_lane: 4};
    vecs[1] = '{obs_rand: 6, ban_rand: 1, obs_lane: 1, ban_lane: 2};
    vecs[2] = '{obs_rand: 7, ban_rand: 7, obs_lane: 2, ban_lane: 3};
    vecs[3] = '{obs_rand: 0, ban_rand: 0, obs_lane: 0, ban_lane: 1};
    vecs[4] = '{obs_rand: 4, ban_rand: 4, obs_lane: 4, ban_lane: 0};
    vecs[5] = '{obs_rand: 5, ban_rand: 3, obs_lane: 0, ban_lane: 3};
    vecs[6] = '{obs_rand: 3, ban_rand: 5, obs_lane: 3, ban_lane: 0};

    bus.frameTick = 0; bus.enable = 1; bus.obstacleRand = 0;
    bus.bananaRand = 0; bus.spawnAck = 0;

    // Lane mapping and collision vectors, each from a fresh reset.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      run_event(vecs[i].obs_rand, vecs[i].ban_rand, vecs[i].obs_lane, vecs[i].ban_lane, $sformatf("vec%0d", i));
    end

    // Events while the obstacle request is stalled are dropped and saturate.
    do_reset();
    bus.obstacleRand = 3'd2; bus.bananaRand = 3'd4; bus.frameTick = 1;
    repeat (PER) cycle();
    repeat (10 * PER) cycle();
    check("drop.count10", int'(bus.dropCount), 10);
    check("drop.req_held", int'(bus.spawnReq), 1);
    check("drop.lane_held", int'(bus.spawnLane), 2);
    repeat (250 * PER) cycle();
    check("drop.sat255", int'(bus.dropCount), 255);
    repeat (3 * PER) cycle();
    check("drop.stay255", int'(bus.dropCount), 255);

    // Reset in the middle of a request clears everything; counter restarts.
    bus.frameTick = 0; bus.spawnAck = 0;
    rst = 1; cycle(); rst = 0;
    check("midrst.req", int'(bus.spawnReq), 0);
    check("midrst.busy", int'(bus.busy), 0);
    check("midrst.drop", int'(bus.dropCount), 0);
    bus.frameTick = 1;
    repeat (PER - 1) cycle();
    check("midrst.no_early_evt", int'(bus.busy), 0);
    cycle();
    check("midrst.evt_after_period", int'(bus.spawnReq), 1);

    // Event on the same edge that the banana request completes is dropped.
    do_reset();
    bus.obstacleRand = 3'd1; bus.bananaRand = 3'd3; bus.frameTick = 1;
    repeat (PER) cycle();
    bus.spawnAck = 1; cycle();
    bus.spawnAck = 0; cycle();
    check("edge.ban_req", int'(bus.spawnReq), 1);
    cycle();
    bus.spawnAck = 1; cycle();
    bus.spawnAck = 0; bus.frameTick = 0;
    check("edge.drop", int'(bus.dropCount), 1);
    check("edge.idle", int'(bus.busy), 0);
    check("edge.req_low", int'(bus.spawnReq), 0);

    // Ack in the same cycle the request first rises is accepted.
    do_reset();
    bus.frameTick = 1;
    repeat (PER - 1) cycle();
    bus.spawnAck = 1; cycle();
    bus.frameTick = 0;
    check("fastack.req", int'(bus.spawnReq), 1);
    cycle();
    check("fastack.gap", int'(bus.spawnReq), 0);
    bus.spawnAck = 0;
    repeat (2) cycle();

    // Repeated obstacle value on consecutive events.
    do_reset();
    run_event(3, 0, 3, 0, "rep1");
`ifdef LANE_REPEAT_AVOID_EN
    run_event(3, 0, 4, 0, "rep2");
`else
    run_event(3, 0, 3, 0, "rep2");
`endif

    // Randomized run against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      bus.frameTick    = ($urandom_range(0, 1) == 1);
      bus.enable       = ($urandom_range(0, 9) != 0);
      bus.obstacleRand = 3'($urandom_range(0, 7));
      bus.bananaRand   = 3'($urandom_range(0, 7));
      bus.spawnAck     = ($urandom_range(0, 2) == 0);
      rst              = ($urandom_range(0, 599) == 0);
      cycle();
    end
    rst = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
